// File: rtl/apb4_slave_regbank_if.sv
// APB4 completer-side signal bundle for the register bank; the requester drives
// select/enable/address/data/strobes, the completer returns read data, ready and error.
interface apb4_slave_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_slave_regbank.sv
// APB4 register bank: RW control words with byte strobes, RO status words, error on bad decode.
// Each transfer takes 2+WAIT_STATES cycles; PREADY stays low for WAIT_STATES access cycles.
module apb4_slave_regbank #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    NUM_RW      = 12,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                     PCLK,
  input  logic                                     PRESETn,
  apb4_slave_regbank_if.slave                      apb,
  input  logic [(NUM_REGS-NUM_RW)*DATA_WIDTH-1:0]  status_i,
  output logic [NUM_RW*DATA_WIDTH-1:0]             ctrl_o,
  output logic [NUM_RW-1:0]                        wr_pulse_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int NUM_RO = NUM_REGS - NUM_RW;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [3:0]            WS         = 4'(WAIT_STATES);
  localparam logic [IDX_W:0]        NREGS_I    = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W:0]        NRW_I      = (IDX_W+1)'(NUM_RW);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  ctrl_q [NUM_RW];
  logic [NUM_RW-1:0]      wr_pulse_q;
  logic [NUM_RW-1:0]      wr_hit;
  logic [IDX_W:0]         idx;
  logic                   err;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  rd_word;

  // Extra top bit keeps the range compares exact even when NUM_REGS fills the address space.
  assign idx = {1'b0, apb.paddr[ADDR_WIDTH-1:LSB]};
  assign err = (|(apb.paddr & ALIGN_MASK)) || (idx >= NREGS_I) ||
               (apb.pwrite && (idx >= NRW_I));

  assign apb.pready  = (state_q == ACCESS) && apb.psel && apb.penable && (cnt_q == WS);
  assign apb.pslverr = apb.pready && err;
  assign wr_en       = apb.pready && apb.pwrite && !err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (!(apb.psel && apb.penable)) begin
          state_d = IDLE;
        end else if (cnt_q == WS) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      wr_hit[k] = wr_en && (idx == (IDX_W+1)'(k));
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k < NUM_RW; k++) begin
        ctrl_q[k] <= RESET_VALUE;
      end
      wr_pulse_q <= '0;
    end else begin
      for (int k = 0; k < NUM_RW; k++) begin
        if (wr_hit[k]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (apb.pstrb[b]) begin
              ctrl_q[k][b*8 +: 8] <= apb.pwdata[b*8 +: 8];
            end
          end
        end
      end
      // An all-zero strobe is a legal no-op write and must not announce a change.
      wr_pulse_q <= (|apb.pstrb) ? wr_hit : '0;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (idx == (IDX_W+1)'(k)) begin
        rd_word = ctrl_q[k];
      end
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (idx == (IDX_W+1)'(NUM_RW + k)) begin
        rd_word = status_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign apb.prdata = (apb.pready && !apb.pwrite && !err) ? rd_word : '0;

  for (genvar k = 0; k < NUM_RW; k++) begin : g_ctrl
    assign ctrl_o[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
  end

  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Bench for apb4_slave_regbank: one instance with no wait states, one with three,
// driven through directed steps then random transfers against a register-array model.
module tb_apb4_slave_regbank;

  localparam int          AW  = 8;
  localparam int          DW  = 32;
  localparam int          NR  = 16;
  localparam int          NRW = 12;
  localparam int          NRO = NR - NRW;
  localparam logic [31:0] RV3 = 32'hC0DE_0000;

  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  logic                 sel0, sel3, penable, pwrite;
  logic [AW-1:0]        paddr;
  logic [DW-1:0]        pwdata;
  logic [DW/8-1:0]      pstrb;
  logic [NRO*DW-1:0]    st0, st3;
  logic [NRW*DW-1:0]    ctrl0, ctrl3;
  logic [NRW-1:0]       pulse0, pulse3;

  apb4_slave_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb4_slave_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  assign bus0.psel    = sel0;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus3.psel    = sel3;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.paddr   = paddr;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;

  apb4_slave_regbank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RW(NRW),
    .WAIT_STATES(0), .RESET_VALUE(32'h0)
  ) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0.slave),
    .status_i(st0), .ctrl_o(ctrl0), .wr_pulse_o(pulse0)
  );

  apb4_slave_regbank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RW(NRW),
    .WAIT_STATES(3), .RESET_VALUE(RV3)
  ) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus3.slave),
    .status_i(st3), .ctrl_o(ctrl3), .wr_pulse_o(pulse3)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mreg [2][NRW];

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [383:0] mpack(input int d);
    logic [383:0] r;
    for (int k = 0; k < NRW; k++) r[k*32 +: 32] = mreg[d][k];
    return r;
  endfunction

  function automatic logic [31:0] mstatus(input int d, input int k);
    return (d != 0) ? st3[k*32 +: 32] : st0[k*32 +: 32];
  endfunction

  function automatic logic o_rdy(input int d);
    return (d != 0) ? bus3.pready : bus0.pready;
  endfunction
  function automatic logic o_err(input int d);
    return (d != 0) ? bus3.pslverr : bus0.pslverr;
  endfunction
  function automatic logic [31:0] o_rdata(input int d);
    return (d != 0) ? bus3.prdata : bus0.prdata;
  endfunction
  function automatic logic [11:0] o_pulse(input int d);
    return (d != 0) ? pulse3 : pulse0;
  endfunction
  function automatic logic [383:0] o_ctrl(input int d);
    return (d != 0) ? ctrl3 : ctrl0;
  endfunction

  task automatic set_sel(input int d, input logic v);
    if (d != 0) sel3 = v; else sel0 = v;
  endtask

  task automatic mreset();
    for (int k = 0; k < NRW; k++) begin
      mreg[0][k] = 32'h0;
      mreg[1][k] = RV3;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge with select dropped,
  // so a following call starts its setup phase with no idle cycle in between.
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    int          idx;
    int          waits;
    logic        done;
    logic        err;
    logic [31:0] exp_rd;
    logic [11:0] exp_pulse;
    idx       = int'(addr) / 4;
    err       = (addr % 4 != 0) || (idx >= NR) || (wr && idx >= NRW);
    exp_rd    = 32'h0;
    if (!wr && !err) exp_rd = (idx < NRW) ? mreg[d][idx] : mstatus(d, idx - NRW);
    exp_pulse = '0;
    if (wr && !err && strb != 4'h0) exp_pulse[idx] = 1'b1;

    set_sel(d, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(posedge PCLK); #1;
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge PCLK);
      if (c == 0) chk("pulse_quiet", o_pulse(d), 0);
      if (o_rdy(d)) begin
        done = 1'b1;
      end else begin
        chk("prdata_wait", o_rdata(d), 0);
        chk("pslverr_wait", o_err(d), 0);
        waits++;
        @(posedge PCLK); #1;
      end
    end
    chk("pready_seen", done, 1);
    chk("wait_cycles", waits, (d != 0) ? 3 : 0);
    chk("pslverr", o_err(d), err);
    chk("prdata", o_rdata(d), exp_rd);
    if (wr && !err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mreg[d][idx][b*8 +: 8] = data[b*8 +: 8];
    @(posedge PCLK); #1;
    set_sel(d, 1'b0);
    penable = 1'b0;
    chk("wr_pulse", o_pulse(d), exp_pulse);
    chk("ctrl", o_ctrl(d), mpack(d));
  endtask

  // Starts a write to the WS=3 instance and kills it in the second access cycle.
  task automatic abort_xfer(input logic [7:0] addr, input logic [31:0] data, input logic use_rst);
    sel3    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = addr;
    pwdata  = data;
    pstrb   = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    chk("abort_pready_a1", bus3.pready, 0);
    @(posedge PCLK); #1;
    if (!use_rst) begin
      sel3    = 1'b0;
      penable = 1'b0;
      @(negedge PCLK);
      chk("abort_pready_a2", bus3.pready, 0);
      chk("abort_pslverr", bus3.pslverr, 0);
      @(posedge PCLK); #1;
      chk("abort_ctrl", ctrl3, mpack(1));
      chk("abort_pulse", pulse3, 0);
    end else begin
      PRESETn = 1'b0;
      #1;
      mreset();
      chk("rst_pready", bus3.pready, 0);
      chk("rst_ctrl3", ctrl3, mpack(1));
      chk("rst_ctrl0", ctrl0, mpack(0));
      @(negedge PCLK);
      chk("rst_pulse3", pulse3, 0);
      sel3    = 1'b0;
      penable = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0;
    sel0 = 1'b0; sel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    st0 = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    st3 = {32'h3333_0004, 32'h3333_0003, 32'h3333_0002, 32'h3333_0001};
    mreset();
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_ctrl0", ctrl0, mpack(0));
    chk("reset_ctrl3", ctrl3, mpack(1));
    chk("reset_pready0", bus0.pready, 0);
    chk("reset_pready3", bus3.pready, 0);
    chk("reset_pslverr0", bus0.pslverr, 0);
    chk("reset_prdata0", bus0.prdata, 0);
    chk("reset_pulse0", pulse0, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // basic write then read-back
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0);

    // byte strobes and the empty-strobe no-op
    xfer(0, 1'b1, 8'h00, 32'h1122_3344, 4'hF);
    xfer(0, 1'b1, 8'h00, 32'hAABB_CCDD, 4'b0101);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'hF);
    chk("strobe_merge", ctrl0[31:0], 32'h11BB_33DD);
    xfer(0, 1'b1, 8'h00, 32'hFFFF_FFFF, 4'h0);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'h0);

    // PENABLE high in IDLE without a setup phase must not start a transfer
    sel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h7777_7777; pstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      chk("no_setup_pready", bus0.pready, 0);
    end
    @(posedge PCLK); #1;
    sel0 = 1'b0; penable = 1'b0;
    chk("no_setup_ctrl", ctrl0, mpack(0));

    // wait states on read and write
    xfer(1, 1'b0, 8'h10, 32'h0, 4'h0);
    xfer(1, 1'b1, 8'h10, 32'h0BAD_F00D, 4'b0011);
    xfer(1, 1'b0, 8'h10, 32'h0, 4'h0);

    // error responses and status reads
    st0[31:0] = 32'h5A5A_0001;
    xfer(0, 1'b1, 8'h30, 32'h1234_5678, 4'hF);
    xfer(0, 1'b0, 8'h40, 32'h0, 4'h0);
    xfer(0, 1'b1, 8'h02, 32'h1234_5678, 4'hF);
    xfer(0, 1'b0, 8'h02, 32'h0, 4'h0);
    xfer(0, 1'b0, 8'h30, 32'h0, 4'h0);
    xfer(0, 1'b0, 8'h3C, 32'h0, 4'h0);
    xfer(0, 1'b1, 8'h2C, 32'hFEED_0011, 4'hF);
    xfer(1, 1'b0, 8'h34, 32'h0, 4'h0);

    // abort by dropping PSEL, then by reset, both mid-access
    xfer(1, 1'b1, 8'h08, 32'hCAFE_F00D, 4'hF);
    abort_xfer(8'h08, 32'h1234_5678, 1'b0);
    xfer(1, 1'b0, 8'h08, 32'h0, 4'h0);
    abort_xfer(8'h08, 32'h1234_5678, 1'b1);
    xfer(1, 1'b0, 8'h08, 32'h0, 4'h0);
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0);

    // back-to-back writes with no idle cycles, then read-after-write
    xfer(0, 1'b1, 8'h00, 32'h0000_00A0, 4'hF);
    xfer(0, 1'b1, 8'h04, 32'h0000_00A1, 4'hF);
    xfer(0, 1'b1, 8'h08, 32'h0000_00A2, 4'hF);
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0);

    // random traffic across both instances
    for (int n = 0; n < 160; n++) begin
      int          d;
      logic [7:0]  a;
      d = int'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 7) == 0) a = a | 8'($urandom_range(1, 3));
      st0 = {$urandom, $urandom, $urandom, $urandom};
      st3 = {$urandom, $urandom, $urandom, $urandom};
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge PCLK); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
